gbuf_read_scheduler: RTL and testbench

GBUF_READ_SCHEDULER -- requirements
Module: gbuf_read_scheduler

---
 rtl/gbuf_read_scheduler.sv | 133 +++++++++++++
 tb/tb_gbuf_read_scheduler.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/gbuf_read_scheduler.sv
// Global-buffer read scheduler: round-robin grants of address bursts to PEs,
// issuing SRAM reads and a one-cycle-delayed PE write enable.
module gbuf_read_scheduler #(
    parameter int N                 = 5,
    parameter int ADDR_WIDTH_GLOBAL = 16,
    parameter int BURST_WIDTH       = 4,
    localparam int GW               = (N > 1) ? $clog2(N) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [ADDR_WIDTH_GLOBAL-1:0] cfg_base,
    input  logic [ADDR_WIDTH_GLOBAL-1:0] cfg_last,
    input  logic [BURST_WIDTH-1:0]       cfg_burst,
    input  logic [N-1:0]                 req,
    output logic                         ren_global,
    output logic [ADDR_WIDTH_GLOBAL-1:0] r_addr,
    output logic [N-1:0]                 wen_pe,
    output logic [GW-1:0]                grant_id,
    output logic                         busy,
    output logic                         done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARB   = 3'd1;
    localparam logic [2:0] S_BURST = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]                   state;
    logic [ADDR_WIDTH_GLOBAL-1:0] addr;
    logic [ADDR_WIDTH_GLOBAL-1:0] last_q;
    logic [BURST_WIDTH-1:0]       burst_q;
    logic [BURST_WIDTH-1:0]       burst_cnt;
    logic                         single_q;
    logic [GW-1:0]                rr_ptr;
    logic [GW-1:0]                rr_next;
    logic [GW-1:0]                pick;
    logic                         found;
    logic [GW:0]                  idx;
    logic                         rd_fire;
    logic                         at_end;
    logic                         at_burst_end;

    // First requesting PE scanning cyclically upward from rr_ptr.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = {1'b0, rr_ptr} + (GW+1)'(i);
            if (idx >= (GW+1)'(N)) idx = idx - (GW+1)'(N);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx[GW-1:0];
            end
        end
    end

    assign rd_fire      = (state == S_BURST) && req[grant_id];
    assign ren_global   = rd_fire;
    assign r_addr       = addr;
    assign at_end       = single_q || (addr == last_q) || (addr == '1);
    assign at_burst_end = (burst_cnt == burst_q - BURST_WIDTH'(1));
    assign rr_next      = (grant_id == GW'(N - 1)) ? '0 : grant_id + GW'(1);
    assign busy         = (state != S_IDLE);
    assign done         = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            addr      <= '0;
            last_q    <= '0;
            burst_q   <= '0;
            burst_cnt <= '0;
            single_q  <= 1'b0;
            rr_ptr    <= '0;
            grant_id  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        last_q   <= cfg_last;
                        burst_q  <= (cfg_burst == '0) ?
                                    BURST_WIDTH'(1) : cfg_burst;
                        single_q <= (cfg_last < cfg_base);
                        addr     <= cfg_base;
                        rr_ptr   <= '0;
                        state    <= S_ARB;
                    end
                end
                S_ARB: begin
                    if (found) begin
                        grant_id  <= pick;
                        burst_cnt <= '0;
                        state     <= S_BURST;
                    end
                end
                S_BURST: begin
                    // A dropped req stalls in place; the grant is kept.
                    if (req[grant_id]) begin
                        if (at_end) begin
                            rr_ptr <= rr_next;
                            state  <= S_DRAIN;
                        end else begin
                            addr <= addr + ADDR_WIDTH_GLOBAL'(1);
                            if (at_burst_end) begin
                                rr_ptr    <= rr_next;
                                burst_cnt <= '0;
                                state     <= S_ARB;
                            end else begin
                                burst_cnt <= burst_cnt + BURST_WIDTH'(1);
                            end
                        end
                    end
                end
                S_DRAIN: state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Delayed one cycle to line up with SRAM read data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wen_pe <= '0;
        end else begin
            wen_pe <= rd_fire ? (N'(1) << grant_id) : '0;
        end
    end

endmodule

// File: tb/tb_gbuf_read_scheduler.sv
// Directed bench for gbuf_read_scheduler: cycle-by-cycle expected outputs.
module tb_gbuf_read_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] cfg_base;
    logic [15:0] cfg_last;
    logic [3:0]  cfg_burst;
    logic [4:0]  req;
    logic        ren_global;
    logic [15:0] r_addr;
    logic [4:0]  wen_pe;
    logic [2:0]  grant_id;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    gbuf_read_scheduler #(
        .N                 (5),
        .ADDR_WIDTH_GLOBAL (16),
        .BURST_WIDTH       (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_base   (cfg_base),
        .cfg_last   (cfg_last),
        .cfg_burst  (cfg_burst),
        .req        (req),
        .ren_global (ren_global),
        .r_addr     (r_addr),
        .wen_pe     (wen_pe),
        .grant_id   (grant_id),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic int oh(input int g);
        return 1 << g;
    endfunction

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Negative addr / grant means "don't care" for that cycle.
    task automatic chk(input string tag, input bit e_ren, input int e_addr,
                       input int e_wen, input int e_g, input bit e_busy,
                       input bit e_done);
        #2;
        cmp({tag, ".ren"}, 32'(ren_global), 32'(e_ren));
        if (e_addr >= 0) cmp({tag, ".addr"}, 32'(r_addr), e_addr);
        cmp({tag, ".wen"}, 32'(wen_pe), e_wen);
        if (e_g >= 0) cmp({tag, ".grant"}, 32'(grant_id), e_g);
        cmp({tag, ".busy"}, 32'(busy), 32'(e_busy));
        cmp({tag, ".done"}, 32'(done), 32'(e_done));
    endtask

    task automatic begin_pass(input int base, input int last, input int bl);
        cfg_base  = 16'(base);
        cfg_last  = 16'(last);
        cfg_burst = 4'(bl);
        start     = 1'b1;
        chk("idle", 0, -1, 0, -1, 0, 0);
        nxt();
        start = 1'b0;
        chk("arb", 0, -1, 0, -1, 1, 0);
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        req       = '0;
        cfg_base  = '0;
        cfg_last  = '0;
        cfg_burst = '0;
        nxt();
        nxt();
        chk("reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        nxt();
        chk("post_reset", 0, 0, 0, 0, 0, 0);

        // Five PEs, bursts of two over 0..9, stray start mid-pass.
        req = 5'b11111;
        begin_pass(0, 9, 2);
        for (int g = 0; g < 5; g++) begin
            if (g != 0) begin
                nxt();
                chk("t1.arb", 0, 2 * g, oh(g - 1), -1, 1, 0);
            end
            for (int k = 0; k < 2; k++) begin
                nxt();
                if (g == 2 && k == 0) begin
                    cfg_base  = 16'd50;
                    cfg_last  = 16'd60;
                    cfg_burst = 4'd7;
                end
                start = (g == 2 && k == 0);
                chk("t1.rd", 1, 2 * g + k, (k == 1) ? oh(g) : 0, g, 1, 0);
            end
        end
        nxt();
        chk("t1.drain", 0, 9, oh(4), -1, 1, 0);
        nxt();
        chk("t1.done", 0, -1, 0, -1, 1, 1);
        nxt();
        chk("t1.idle", 0, -1, 0, -1, 0, 0);

        // Only PE2 requests; it is re-granted after rr_ptr moves past it.
        req = 5'b00100;
        begin_pass(4, 7, 3);
        nxt(); chk("t2.rd4", 1, 4, 0, 2, 1, 0);
        nxt(); chk("t2.rd5", 1, 5, oh(2), 2, 1, 0);
        nxt(); chk("t2.rd6", 1, 6, oh(2), 2, 1, 0);
        nxt(); chk("t2.arb", 0, 7, oh(2), -1, 1, 0);
        nxt(); chk("t2.rd7", 1, 7, 0, 2, 1, 0);
        nxt(); chk("t2.drain", 0, 7, oh(2), -1, 1, 0);
        nxt(); chk("t2.done", 0, -1, 0, -1, 1, 1);
        nxt(); chk("t2.idle", 0, -1, 0, -1, 0, 0);

        // PE1 drops its request for three cycles mid-burst.
        req = 5'b00010;
        begin_pass(20, 23, 4);
        nxt(); chk("t3.rd20", 1, 20, 0, 1, 1, 0);
        nxt(); chk("t3.rd21", 1, 21, oh(1), 1, 1, 0);
        nxt(); req = 5'b00000; chk("t3.stall0", 0, 22, oh(1), 1, 1, 0);
        nxt(); chk("t3.stall1", 0, 22, 0, 1, 1, 0);
        nxt(); chk("t3.stall2", 0, 22, 0, 1, 1, 0);
        nxt(); req = 5'b00010; chk("t3.rd22", 1, 22, 0, 1, 1, 0);
        nxt(); chk("t3.rd23", 1, 23, oh(1), 1, 1, 0);
        nxt(); chk("t3.drain", 0, 23, oh(1), -1, 1, 0);
        nxt(); chk("t3.done", 0, -1, 0, -1, 1, 1);
        nxt(); chk("t3.idle", 0, -1, 0, -1, 0, 0);

        // Burst 0 acts as 1; ARB waits while req is empty.
        req = 5'b00000;
        begin_pass(5, 5, 0);
        nxt(); chk("t4.arb_wait", 0, -1, 0, -1, 1, 0);
        nxt(); req = 5'b11111; chk("t4.arb_go", 0, -1, 0, -1, 1, 0);
        nxt(); chk("t4.rd5", 1, 5, 0, 0, 1, 0);
        nxt(); chk("t4.drain", 0, 5, oh(0), -1, 1, 0);
        nxt(); chk("t4.done", 0, -1, 0, -1, 1, 1);
        nxt(); chk("t4.idle", 0, -1, 0, -1, 0, 0);

        // last < base: a single read at base.
        begin_pass(9, 3, 2);
        nxt(); chk("t5.rd9", 1, 9, 0, 0, 1, 0);
        nxt(); chk("t5.drain", 0, 9, oh(0), -1, 1, 0);
        nxt(); chk("t5.done", 0, -1, 0, -1, 1, 1);
        nxt(); chk("t5.idle", 0, -1, 0, -1, 0, 0);

        // Reset right after a read kills the pending write enable.
        begin_pass(0, 30, 4);
        nxt(); chk("t6.rd0", 1, 0, 0, 0, 1, 0);
        rst = 1'b0;
        nxt(); chk("t6.rst", 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        nxt(); chk("t6.after", 0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
